// File: rtl/gshare_bp_if.sv
// Fetch-side predict port plus resolve-side update port of the gshare predictor.
// The predictor drives ready/pred_taken/pred_ghr; fetch and commit drive everything else.
// Pure wiring; no storage or timing of its own.
interface gshare_bp_if #(
    parameter int PC_W   = 32,
    parameter int HIST_W = 12
);
    logic              ready;
    logic              pred_en;
    logic [PC_W-1:0]   pred_pc;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_ghr;
    logic              upd_en;
    logic [PC_W-1:0]   upd_pc;
    logic [HIST_W-1:0] upd_ghr;
    logic              upd_taken;
    logic              upd_mispredict;

    // Fetch/commit side
    modport master (
        input  ready, pred_taken, pred_ghr,
        output pred_en, pred_pc, upd_en, upd_pc, upd_ghr, upd_taken, upd_mispredict
    );

    // Predictor side
    modport slave (
        output ready, pred_taken, pred_ghr,
        input  pred_en, pred_pc, upd_en, upd_pc, upd_ghr, upd_taken, upd_mispredict
    );
endinterface

// File: rtl/gshare_bp.sv
// Gshare branch predictor: PHT of saturating counters indexed by PC xor speculative GHR.
// Predict is combinational (0 cycles); updates and GHR changes land at the next clk edge.
// No backpressure: ready stays low for the DEPTH-cycle clearing sweep after reset.
// Macro BP_GSHARE_EN enables history hashing; when undefined the block is a plain bimodal predictor.
module gshare_bp #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 12,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 12
) (
    input  logic         clk,
    input  logic         rst,
    gshare_bp_if.slave   bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;
    logic [CTR_W-1:0]   pht_q [DEPTH];

    logic               run;
    logic [IDX_W-1:0]   pred_idx, upd_idx;
    logic [CTR_W-1:0]   pred_ctr, upd_ctr, upd_ctr_nxt;
    logic               pht_we;
    logic [IDX_W-1:0]   pht_widx;
    logic [CTR_W-1:0]   pht_wdat;
    logic               pred_taken_int;

    assign run = (state_q == ST_RUN);

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [HIST_W-1:0] spec_hist, rep_hist;

    assign pred_idx = bp.pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign upd_idx  = bp.upd_pc[IDX_W+1:2]  ^ IDX_W'(bp.upd_ghr);
    assign bp.pred_ghr = ghr_q;

    // A one-bit history degenerates to just the newest outcome
    if (HIST_W == 1) begin : g_hist1
        assign spec_hist = pred_taken_int;
        assign rep_hist  = bp.upd_taken;
    end else begin : g_histn
        assign spec_hist = {ghr_q[HIST_W-2:0], pred_taken_int};
        assign rep_hist  = {bp.upd_ghr[HIST_W-2:0], bp.upd_taken};
    end

    // History: repair from a resolved mispredict wins over the speculative shift
    always_comb begin
        ghr_d = ghr_q;
        if (run) begin
            if (bp.upd_en && bp.upd_mispredict) begin
                ghr_d = rep_hist;
            end else if (bp.pred_en) begin
                ghr_d = spec_hist;
            end
        end
    end

    // History register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic unused_hist;

    assign pred_idx    = bp.pred_pc[IDX_W+1:2];
    assign upd_idx     = bp.upd_pc[IDX_W+1:2];
    assign bp.pred_ghr = '0;
    assign unused_hist = ^{bp.upd_ghr, bp.upd_mispredict};
`endif

    logic unused_pc;
    assign unused_pc = ^{bp.pred_pc, bp.upd_pc};

    assign pred_ctr       = pht_q[pred_idx];
    assign upd_ctr        = pht_q[upd_idx];
    assign pred_taken_int = run & bp.pred_en & pred_ctr[CTR_W-1];
    assign bp.pred_taken  = pred_taken_int;
    assign bp.ready       = run;

    // Saturating step of the counter being trained
    always_comb begin
        upd_ctr_nxt = upd_ctr;
        if (bp.upd_taken) begin
            if (upd_ctr != CTR_MAX) upd_ctr_nxt = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_ctr_nxt = upd_ctr - 1'b1;
        end
    end

    // Sweep FSM and PHT write-port selection: sweep owns the port until RUN
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        pht_we     = 1'b0;
        pht_widx   = upd_idx;
        pht_wdat   = upd_ctr_nxt;
        if (state_q == ST_INIT) begin
            pht_we     = 1'b1;
            pht_widx   = init_idx_q;
            pht_wdat   = WEAK_T;
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == {IDX_W{1'b1}}) state_d = ST_RUN;
        end else begin
            pht_we = bp.upd_en;
        end
    end

    // FSM state and sweep pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // PHT storage: cleared by the sweep, not by reset
    always_ff @(posedge clk) begin
        if (pht_we) pht_q[pht_widx] <= pht_wdat;
    end
endmodule
